// File: rtl/std_cache_pkg.sv
// Shared types for the standard data-cache subsystem (bypass arbitration slice).
// Bypass port requests/responses, AMO encoding and the bypass arbiter state type.
package std_cache_pkg;

   // Upper bound on bypass requesters; the port index rides in id[1:0].
   localparam int unsigned BYPASS_ARB_MAX_PORTS = 4;
   localparam int unsigned BYPASS_ARB_IDX_W     = $clog2(BYPASS_ARB_MAX_PORTS);

   typedef enum logic [3:0] {
      AMO_NONE = 4'h0,
      AMO_LR   = 4'h1,
      AMO_SC   = 4'h2,
      AMO_SWAP = 4'h3,
      AMO_ADD  = 4'h4,
      AMO_AND  = 4'h5,
      AMO_OR   = 4'h6,
      AMO_XOR  = 4'h7,
      AMO_MAX  = 4'h8,
      AMO_MAXU = 4'h9,
      AMO_MIN  = 4'hA,
      AMO_MINU = 4'hB
   } amo_t;

   typedef struct packed {
      logic        req;
      logic        we;
      amo_t        amo;
      logic [3:0]  id;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  be;
      logic [1:0]  size;
   } bypass_req_t;

   typedef struct packed {
      logic        gnt;
      logic        valid;
      logic [63:0] rdata;
   } bypass_rsp_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2
   } bypass_arb_state_e;

   // Adapter transaction id carrying the originating port index.
   function automatic logic [3:0] bypass_arb_id(input logic [BYPASS_ARB_IDX_W-1:0] idx);
      return {2'b00, idx};
   endfunction

endpackage

// File: rtl/std_cache_rr_pick.sv
// Combinational round-robin pick: first set request at or after rr_i, wrapping.
// Shared by the bypass arbiter and the writeback port arbitration.
module std_cache_rr_pick
   import std_cache_pkg::*;
#(
   parameter int unsigned NrPorts = 3
) (
   input  logic [NrPorts-1:0]          req_i,
   input  logic [BYPASS_ARB_IDX_W-1:0] rr_i,
   output logic [NrPorts-1:0]          gnt_o,
   output logic [BYPASS_ARB_IDX_W-1:0] idx_o,
   output logic                        valid_o
);

   // Scan ports starting at the pointer; rr_i < NrPorts so one wrap subtract suffices.
   always_comb begin
      int unsigned p;
      p       = 0;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int unsigned i = 0; i < NrPorts; i++) begin
         p = 32'(rr_i) + i;
         if (p >= NrPorts) begin
            p = p - NrPorts;
         end
         if (!valid_o && req_i[p]) begin
            valid_o  = 1'b1;
            gnt_o[p] = 1'b1;
            idx_o    = p[BYPASS_ARB_IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/std_cache_bypass_arbiter.sv
// Round-robin arbiter sharing the uncached bypass port between NR_PORTS requesters.
// One transaction outstanding at the adapter; responses are routed back by latched index.
// Optional build macro: STD_CACHE_BYPASS_ARB_PERF_EN adds grant and stall counters.
module std_cache_bypass_arbiter
   import std_cache_pkg::*;
#(
   parameter int unsigned NR_PORTS = 3
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  bypass_req_t [NR_PORTS-1:0]   req_i,
   output bypass_rsp_t [NR_PORTS-1:0]   rsp_o,
   output bypass_req_t                  adp_req_o,
   input  bypass_rsp_t                  adp_rsp_i,
`ifdef STD_CACHE_BYPASS_ARB_PERF_EN
   output logic [NR_PORTS-1:0][31:0]    gnt_cnt_o,
   output logic [31:0]                  stall_cnt_o,
`endif
   output logic                         busy_o
);

   if (NR_PORTS < 2 || NR_PORTS > BYPASS_ARB_MAX_PORTS) begin : gen_bad_cfg
      $error("NR_PORTS must be within 2..BYPASS_ARB_MAX_PORTS");
   end

   bypass_arb_state_e             state_q, state_d;
   logic [BYPASS_ARB_IDX_W-1:0]   rr_q, rr_d;
   logic [BYPASS_ARB_IDX_W-1:0]   idx_q, idx_d;
   bypass_req_t                   req_q, req_d;

   logic [NR_PORTS-1:0]           req_vec;
   logic [NR_PORTS-1:0]           pick_gnt;
   logic [BYPASS_ARB_IDX_W-1:0]   pick_idx;
   logic                          pick_valid;
   logic [NR_PORTS-1:0]           gnt_vec;
   logic                          done;

   // Gather the per-port request qualifiers.
   always_comb begin
      req_vec = '0;
      for (int unsigned k = 0; k < NR_PORTS; k++) begin
         req_vec[k] = req_i[k].req;
      end
   end

   std_cache_rr_pick #(
      .NrPorts (NR_PORTS)
   ) u_rr_pick (
      .req_i   (req_vec),
      .rr_i    (rr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // Grants only exist in IDLE and never while reset is held.
   assign gnt_vec = (rst_ni && state_q == IDLE) ? pick_gnt : '0;

   // Transaction ends on adapter valid in WAIT_RSP, or gnt+valid together in REQ.
   assign done = (state_q == WAIT_RSP && adp_rsp_i.valid) ||
                 (state_q == REQ && adp_rsp_i.gnt && adp_rsp_i.valid);

   // State register, round-robin pointer and latched request.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rr_q    <= '0;
         idx_q   <= '0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         idx_q   <= idx_d;
         req_q   <= req_d;
      end
   end

   // Next-state: accept in IDLE, hand off in REQ, wait for completion in WAIT_RSP.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      idx_d   = idx_q;
      req_d   = req_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               for (int unsigned k = 0; k < NR_PORTS; k++) begin
                  if (pick_gnt[k]) begin
                     req_d = req_i[k];
                  end
               end
               idx_d   = pick_idx;
               rr_d    = (pick_idx == BYPASS_ARB_IDX_W'(NR_PORTS - 1)) ? '0 : pick_idx + 2'd1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (adp_rsp_i.gnt) begin
               state_d = adp_rsp_i.valid ? IDLE : WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (adp_rsp_i.valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: grant pulse, adapter request in REQ, completion routed to idx_q.
   always_comb begin
      rsp_o     = '0;
      adp_req_o = '0;
      busy_o    = 1'b0;
      if (rst_ni) begin
         busy_o = (state_q != IDLE);
         for (int unsigned k = 0; k < NR_PORTS; k++) begin
            rsp_o[k].gnt = gnt_vec[k];
         end
         if (state_q == REQ) begin
            adp_req_o     = req_q;
            adp_req_o.req = 1'b1;
            adp_req_o.id  = bypass_arb_id(idx_q);
         end
         if (done) begin
            for (int unsigned k = 0; k < NR_PORTS; k++) begin
               if (idx_q == BYPASS_ARB_IDX_W'(k)) begin
                  rsp_o[k].valid = 1'b1;
                  rsp_o[k].rdata = adp_rsp_i.rdata;
               end
            end
         end
      end
   end

`ifdef STD_CACHE_BYPASS_ARB_PERF_EN
   logic [NR_PORTS-1:0][31:0] gnt_cnt_q, gnt_cnt_d;
   logic [31:0]               stall_cnt_q, stall_cnt_d;
   logic                      stall;

   // A cycle stalls when any requesting port is left without a grant.
   assign stall = |(req_vec & ~gnt_vec);

   // Saturating counter increments.
   always_comb begin
      gnt_cnt_d   = gnt_cnt_q;
      stall_cnt_d = stall_cnt_q;
      for (int unsigned k = 0; k < NR_PORTS; k++) begin
         if (gnt_vec[k] && gnt_cnt_q[k] != 32'hFFFF_FFFF) begin
            gnt_cnt_d[k] = gnt_cnt_q[k] + 32'd1;
         end
      end
      if (rst_ni && stall && stall_cnt_q != 32'hFFFF_FFFF) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         gnt_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         gnt_cnt_q   <= gnt_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign gnt_cnt_o   = gnt_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_std_cache_bypass_arbiter.sv
// Self-checking bench for std_cache_bypass_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
module tb_std_cache_bypass_arbiter;
   import std_cache_pkg::*;

   localparam int N = 3;

   logic                 clk = 1'b0;
   logic                 rst_n;
   bypass_req_t [N-1:0]  req;
   bypass_rsp_t [N-1:0]  rsp;
   bypass_req_t          adp_req;
   bypass_rsp_t          adp_rsp;
   logic                 busy;
`ifdef STD_CACHE_BYPASS_ARB_PERF_EN
   logic [N-1:0][31:0]   gnt_cnt;
   logic [31:0]          stall_cnt;
`endif

   std_cache_bypass_arbiter #(
      .NR_PORTS (N)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_i       (req),
      .rsp_o       (rsp),
      .adp_req_o   (adp_req),
      .adp_rsp_i   (adp_rsp),
`ifdef STD_CACHE_BYPASS_ARB_PERF_EN
      .gnt_cnt_o   (gnt_cnt),
      .stall_cnt_o (stall_cnt),
`endif
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   int          vectors;
   int          miscompares;
   // Requester-side view and model state.
   bypass_req_t pend_q [N];
   logic [N-1:0] pend_v;
   int          m_rr;
   int          m_stall;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   function automatic bypass_req_t rand_req();
      bypass_req_t r;
      r.req   = 1'b1;
      r.we    = 1'($urandom);
      r.amo   = ($urandom_range(0, 1) == 0) ? AMO_NONE : amo_t'(4'($urandom_range(1, 11)));
      r.id    = 4'($urandom);
      r.addr  = {$urandom, $urandom};
      r.wdata = {$urandom, $urandom};
      r.be    = 8'($urandom);
      r.size  = 2'($urandom);
      return r;
   endfunction

   // First pending port at or after rr, wrapping modulo N.
   function automatic int model_pick(input logic [N-1:0] v, input int rr);
      for (int i = 0; i < N; i++) begin
         int p;
         p = (rr + i) % N;
         if (v[p]) return p;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] gnts();
      logic [N-1:0] g;
      for (int k = 0; k < N; k++) g[k] = rsp[k].gnt;
      return g;
   endfunction

   function automatic logic [N-1:0] valids();
      logic [N-1:0] v;
      for (int k = 0; k < N; k++) v[k] = rsp[k].valid;
      return v;
   endfunction

   task automatic drive_inputs();
      for (int k = 0; k < N; k++) req[k] = pend_v[k] ? pend_q[k] : '0;
   endtask

   task automatic apply_reset();
      pend_v  = '0;
      drive_inputs();
      adp_rsp = '0;
      rst_n   = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n   = 1'b1;
      m_rr    = 0;
      m_stall = 0;
   endtask

   // One full transaction starting in an IDLE cycle; adapter gnt after gnt_dly REQ cycles,
   // valid val_dly cycles after gnt. keep: the granted port immediately re-requests.
   task automatic run_txn(input int gnt_dly, input int val_dly, input logic [63:0] rd,
                          input bit keep, output int got);
      int           e;
      bypass_req_t  g, exp;
      logic [N-1:0] onehot, gv, ev;
      bit           fin;
      drive_inputs();
      adp_rsp = '0;
      e = model_pick(pend_v, m_rr);
      onehot = '0;
      if (e >= 0) onehot[e] = 1'b1;
      if ((pend_v & ~onehot) != '0) m_stall++;
      @(negedge clk);
      gv  = gnts();
      got = -1;
      for (int k = N - 1; k >= 0; k--) if (gv[k]) got = k;
      vectors++;
      if (gv !== onehot) begin
         miscompares++;
         $display("FAIL grant: got %b required %b", gv, onehot);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_idle: got %b required 0", busy);
      end
      @(posedge clk); #1;
      if (e < 0) return;
      g    = pend_q[e];
      m_rr = (e + 1) % N;
      if (keep) pend_q[e] = rand_req();
      else pend_v[e] = 1'b0;
      drive_inputs();
      exp     = g;
      exp.req = 1'b1;
      exp.id  = 4'(e);
      for (int c = 0; c <= gnt_dly; c++) begin
         adp_rsp       = '0;
         adp_rsp.rdata = {$urandom, $urandom};
         fin           = 1'b0;
         if (c == gnt_dly) begin
            adp_rsp.gnt = 1'b1;
            if (val_dly == 0) begin
               adp_rsp.valid = 1'b1;
               adp_rsp.rdata = rd;
               fin           = 1'b1;
            end
         end
         if (pend_v != '0) m_stall++;
         @(negedge clk);
         vectors++;
         if (adp_req !== exp) begin
            miscompares++;
            $display("FAIL adp_req: got %h required %h", adp_req, exp);
         end
         vectors++;
         if (gnts() !== '0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL req_phase: got gnt %b busy %b required gnt 0 busy 1", gnts(), busy);
         end
         ev = fin ? onehot : '0;
         vectors++;
         if (valids() !== ev) begin
            miscompares++;
            $display("FAIL valid_req: got %b required %b", valids(), ev);
         end
         if (fin) begin
            vectors++;
            if (rsp[e].rdata !== rd) begin
               miscompares++;
               $display("FAIL rdata_req: got %h required %h", rsp[e].rdata, rd);
            end
         end
         @(posedge clk); #1;
      end
      for (int c = 1; c <= val_dly; c++) begin
         adp_rsp       = '0;
         adp_rsp.gnt   = 1'($urandom);
         adp_rsp.rdata = {$urandom, $urandom};
         fin           = (c == val_dly);
         if (fin) begin
            adp_rsp.valid = 1'b1;
            adp_rsp.rdata = rd;
         end
         if (pend_v != '0) m_stall++;
         @(negedge clk);
         vectors++;
         if (adp_req.req !== 1'b0 || gnts() !== '0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_phase: got req %b gnt %b busy %b required 0 0 1",
                     adp_req.req, gnts(), busy);
         end
         ev = fin ? onehot : '0;
         vectors++;
         if (valids() !== ev) begin
            miscompares++;
            $display("FAIL valid_wait: got %b required %b", valids(), ev);
         end
         if (fin) begin
            vectors++;
            if (rsp[e].rdata !== rd) begin
               miscompares++;
               $display("FAIL rdata_wait: got %h required %h", rsp[e].rdata, rd);
            end
         end
         @(posedge clk); #1;
      end
      adp_rsp = '0;
   endtask

   task automatic test_reset();
      int got;
      rst_n = 1'b0;
      for (int k = 0; k < N; k++) pend_q[k] = rand_req();
      pend_v = '1;
      drive_inputs();
      adp_rsp       = '0;
      adp_rsp.gnt   = 1'b1;
      adp_rsp.valid = 1'b1;
      adp_rsp.rdata = {$urandom, $urandom};
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         vectors++;
         if (rsp !== '0 || adp_req !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rsp %h adp %h busy %b required all 0",
                     rsp, adp_req, busy);
         end
`ifdef STD_CACHE_BYPASS_ARB_PERF_EN
         if (c == 1) begin
            vectors++;
            if (gnt_cnt !== '0 || stall_cnt !== '0) begin
               miscompares++;
               $display("FAIL reset_perf: got %h %h required 0", gnt_cnt, stall_cnt);
            end
         end
`endif
         @(posedge clk); #1;
      end
      rst_n   = 1'b1;
      adp_rsp = '0;
      m_rr    = 0;
      m_stall = 0;
      run_txn(0, 0, {$urandom, $urandom}, 1'b0, got);
      vectors++;
      if (got !== 0) begin
         miscompares++;
         $display("FAIL reset_first_gnt: got port %0d required 0", got);
      end
      pend_v = '0;
      drive_inputs();
   endtask

   task automatic test_single_read();
      int got;
      pend_v          = 3'b010;
      pend_q[1]       = rand_req();
      pend_q[1].we    = 1'b0;
      pend_q[1].amo   = AMO_NONE;
      pend_q[1].addr  = 64'h8000_0010;
      run_txn(1, 3, 64'hDEAD_BEEF, 1'b0, got);
      vectors++;
      if (got !== 1) begin
         miscompares++;
         $display("FAIL single_read_port: got %0d required 1", got);
      end
   endtask

   task automatic test_same_cycle();
      int got0, got1;
      int a;
      a = $urandom_range(0, N - 1);
      pend_v    = '0;
      pend_v[a] = 1'b1;
      pend_q[a] = rand_req();
      pend_v[(a + 1) % N] = 1'b1;
      pend_q[(a + 1) % N] = rand_req();
      run_txn(0, 0, {$urandom, $urandom}, 1'b0, got0);
      run_txn(0, 0, {$urandom, $urandom}, 1'b0, got1);
      vectors++;
      if (got0 === got1) begin
         miscompares++;
         $display("FAIL same_cycle_both: got ports %0d and %0d required distinct", got0, got1);
      end
   endtask

   task automatic test_fairness();
      int got;
      int cnt [N];
      apply_reset();
      for (int k = 0; k < N; k++) begin
         pend_q[k] = rand_req();
         cnt[k]    = 0;
      end
      pend_v = '1;
      for (int t = 0; t < 6; t++) begin
         run_txn($urandom_range(0, 2), $urandom_range(0, 2), {$urandom, $urandom}, 1'b1, got);
         vectors++;
         if (got !== t % 3) begin
            miscompares++;
            $display("FAIL fair_order: txn %0d got port %0d required %0d", t, got, t % 3);
         end
         if (got >= 0) cnt[got]++;
      end
      for (int k = 0; k < N; k++) begin
         vectors++;
         if (cnt[k] !== 2) begin
            miscompares++;
            $display("FAIL fair_count: port %0d got %0d grants required 2", k, cnt[k]);
         end
      end
`ifdef STD_CACHE_BYPASS_ARB_PERF_EN
      for (int k = 0; k < N; k++) begin
         vectors++;
         if (gnt_cnt[k] !== 32'd2) begin
            miscompares++;
            $display("FAIL perf_gnt_cnt: port %0d got %0d required 2", k, gnt_cnt[k]);
         end
      end
      vectors++;
      if (stall_cnt !== 32'(m_stall)) begin
         miscompares++;
         $display("FAIL perf_stall_cnt: got %0d required %0d", stall_cnt, m_stall);
      end
`endif
      pend_v = '0;
      drive_inputs();
   endtask

   task automatic test_reset_in_wait();
      pend_v    = '0;
      pend_v[2] = 1'b1;
      pend_q[2] = rand_req();
      drive_inputs();
      adp_rsp = '0;
      @(negedge clk);
      vectors++;
      if (gnts() !== 3'b100) begin
         miscompares++;
         $display("FAIL rst_wait_gnt: got %b required 100", gnts());
      end
      @(posedge clk); #1;
      pend_v = '0;
      drive_inputs();
      adp_rsp.gnt = 1'b1;
      @(posedge clk); #1;
      adp_rsp = '0;
      rst_n   = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || rsp !== '0 || adp_req !== '0) begin
         miscompares++;
         $display("FAIL rst_wait_hold: got busy %b rsp %h adp %h required 0", busy, rsp, adp_req);
      end
      @(posedge clk); #1;
      rst_n   = 1'b1;
      m_rr    = 0;
      m_stall = 0;
      for (int c = 0; c < 3; c++) begin
         adp_rsp.valid = 1'b1;
         adp_rsp.gnt   = 1'($urandom);
         adp_rsp.rdata = {$urandom, $urandom};
         @(negedge clk);
         vectors++;
         if (valids() !== '0 || busy !== 1'b0 || adp_req.req !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wait_drop: got valid %b busy %b req %b required 0 0 0",
                     valids(), busy, adp_req.req);
         end
         @(posedge clk); #1;
      end
      adp_rsp = '0;
   endtask

   task automatic test_random();
      int got;
      for (int t = 0; t < 40; t++) begin
         for (int k = 0; k < N; k++) begin
            if (!pend_v[k] && $urandom_range(0, 1) == 1) begin
               pend_v[k] = 1'b1;
               pend_q[k] = rand_req();
            end
         end
         if (pend_v == '0) begin
            got = $urandom_range(0, N - 1);
            pend_v[got] = 1'b1;
            pend_q[got] = rand_req();
         end
         run_txn($urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom},
                 1'($urandom), got);
      end
      pend_v = '0;
      drive_inputs();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      m_rr        = 0;
      m_stall     = 0;
      pend_v      = '0;
      req         = '0;
      adp_rsp     = '0;
      rst_n       = 1'b0;
      test_reset();
      test_single_read();
      test_same_cycle();
      test_fairness();
      test_reset_in_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
